// File: rtl/vga_timing_pkg.sv
// Shared constants for the VGA timing generator: 640x480@60 defaults, mode codes, bar colours.
package vga_timing_pkg;

  localparam int DEF_CLK_DIV = 2;
  localparam int DEF_H_SYNC  = 96;
  localparam int DEF_H_BP    = 48;
  localparam int DEF_H_ACT   = 640;
  localparam int DEF_H_FP    = 16;
  localparam int DEF_V_SYNC  = 2;
  localparam int DEF_V_BP    = 33;
  localparam int DEF_V_ACT   = 480;
  localparam int DEF_V_FP    = 10;
  localparam int DEF_GRID    = 10;

  typedef enum logic [1:0] {
    MODE_EXT   = 2'd0,
    MODE_BARS  = 2'd1,
    MODE_GRID  = 2'd2,
    MODE_BLACK = 2'd3
  } mode_e;

  localparam logic [23:0] COL_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] COL_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] COL_CYAN    = 24'h00FFFF;
  localparam logic [23:0] COL_GREEN   = 24'h00FF00;
  localparam logic [23:0] COL_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] COL_RED     = 24'hFF0000;
  localparam logic [23:0] COL_BLUE    = 24'h0000FF;
  localparam logic [23:0] COL_BLACK   = 24'h000000;

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_colour = COL_WHITE;
      3'd1:    bar_colour = COL_YELLOW;
      3'd2:    bar_colour = COL_CYAN;
      3'd3:    bar_colour = COL_GREEN;
      3'd4:    bar_colour = COL_MAGENTA;
      3'd5:    bar_colour = COL_RED;
      3'd6:    bar_colour = COL_BLUE;
      default: bar_colour = COL_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/vga_pattern_gen.sv
// Combinational test-pattern source: active-area pixel coordinates and mode to a 24-bit colour.
module vga_pattern_gen
  import vga_timing_pkg::*;
#(
  parameter int XW    = 10,
  parameter int YW    = 9,
  parameter int H_ACT = DEF_H_ACT,
  parameter int GRID  = DEF_GRID
) (
  input  logic [XW-1:0] pix_x_i,
  input  logic [YW-1:0] pix_y_i,
  input  mode_e         mode_i,
  output logic [23:0]   rgb_o
);

  localparam int BAR_W = (H_ACT / 8 > 0) ? H_ACT / 8 : 1;
  localparam int GRD   = (GRID > 0) ? GRID : 1;

  logic [31:0] x_ext, y_ext, bar_idx, x_mod, y_mod;
  logic [2:0]  bar_sel;

  assign x_ext   = 32'(pix_x_i);
  assign y_ext   = 32'(pix_y_i);
  // Constant divisors only; the last bar absorbs any remainder when H_ACT is not a multiple of 8.
  assign bar_idx = x_ext / 32'(BAR_W);
  assign bar_sel = (bar_idx > 32'd7) ? 3'd7 : bar_idx[2:0];
  assign x_mod   = x_ext % 32'(GRD);
  assign y_mod   = y_ext % 32'(GRD);

  always_comb begin
    rgb_o = COL_BLACK;
    case (mode_i)
      MODE_BARS: rgb_o = bar_colour(bar_sel);
      MODE_GRID: rgb_o = (x_mod == 32'd0 || y_mod == 32'd0) ? COL_WHITE : COL_BLACK;
      default:   rgb_o = COL_BLACK;
    endcase
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-enable divider, h/v counters, pixel-fetch handshake,
// frame-latched pattern mode and a one-pixel-tick registered output stage.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int H_ACT    = DEF_H_ACT,
  parameter int H_FP     = DEF_H_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int V_ACT    = DEF_V_ACT,
  parameter int V_FP     = DEF_V_FP,
  parameter bit SYNC_POL = 1'b0,
  parameter int GRID     = DEF_GRID,
  localparam int XW      = $clog2(H_ACT),
  localparam int YW      = $clog2(V_ACT)
) (
  input  logic          clk_50m,
  input  logic          rst_n,
  input  logic [1:0]    mode,
  input  logic [23:0]   rgb_in,
  output logic          pix_req,
  output logic [XW-1:0] pix_x,
  output logic [YW-1:0] pix_y,
  output logic [7:0]    red,
  output logic [7:0]    green,
  output logic [7:0]    blue,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic          frame_start
);

  localparam int H_TOT = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int V_TOT = V_SYNC + V_BP + V_ACT + V_FP;
  localparam int H_OFF = H_SYNC + H_BP;
  localparam int V_OFF = V_SYNC + V_BP;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);
  localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] div_q, div_d;
  logic [HW-1:0] h_q, h_d, h_rel;
  logic [VW-1:0] v_q, v_d, v_rel;
  mode_e         mode_q, mode_d;
  logic          pe, h_wrap, h_act, v_act, act;
  logic [23:0]   pat_rgb;

  logic          hs_q, hs_d, vs_q, vs_d, de_q, de_d, fs_q, fs_d;
  logic [23:0]   rgb_q, rgb_d;

  // Stage 0: pixel enable, raster counters and active-area decode
  assign pe     = (div_q == DW'(CLK_DIV - 1));
  assign h_wrap = (h_q == HW'(H_TOT - 1));
  assign h_act  = (h_q >= HW'(H_OFF)) && (h_q < HW'(H_OFF + H_ACT));
  assign v_act  = (v_q >= VW'(V_OFF)) && (v_q < VW'(V_OFF + V_ACT));
  assign act    = h_act && v_act;
  assign h_rel  = h_q - HW'(H_OFF);
  assign v_rel  = v_q - VW'(V_OFF);

  assign pix_req = act && pe;
  assign pix_x   = act ? h_rel[XW-1:0] : '0;
  assign pix_y   = act ? v_rel[YW-1:0] : '0;

  always_comb begin
    div_d  = pe ? '0 : div_q + 1'b1;
    h_d    = h_q;
    v_d    = v_q;
    mode_d = mode_q;
    if (pe) begin
      h_d = h_wrap ? '0 : h_q + 1'b1;
      if (h_wrap) v_d = (v_q == VW'(V_TOT - 1)) ? '0 : v_q + 1'b1;
      // Mode only changes at the top-left corner so a frame never mixes sources
      if (h_q == '0 && v_q == '0) mode_d = mode_e'(mode);
    end
  end

  vga_pattern_gen #(
    .XW    (XW),
    .YW    (YW),
    .H_ACT (H_ACT),
    .GRID  (GRID)
  ) u_pattern (
    .pix_x_i (pix_x),
    .pix_y_i (pix_y),
    .mode_i  (mode_q),
    .rgb_o   (pat_rgb)
  );

  // Stage 1: registered sync, data enable and colour, one pixel tick behind the counters
  always_comb begin
    hs_d  = hs_q;
    vs_d  = vs_q;
    de_d  = de_q;
    rgb_d = rgb_q;
    fs_d  = pe && act && (h_q == HW'(H_OFF)) && (v_q == VW'(V_OFF));
    if (pe) begin
      hs_d  = (h_q < HW'(H_SYNC)) ? SYNC_POL : ~SYNC_POL;
      vs_d  = (v_q < VW'(V_SYNC)) ? SYNC_POL : ~SYNC_POL;
      de_d  = act;
      rgb_d = !act ? 24'h0 : (mode_q == MODE_EXT) ? rgb_in : pat_rgb;
    end
  end

  always_ff @(posedge clk_50m) begin
    if (!rst_n) begin
      div_q  <= '0;
      h_q    <= '0;
      v_q    <= '0;
      mode_q <= MODE_EXT;
      hs_q   <= ~SYNC_POL;
      vs_q   <= ~SYNC_POL;
      de_q   <= 1'b0;
      fs_q   <= 1'b0;
      rgb_q  <= '0;
    end else begin
      div_q  <= div_d;
      h_q    <= h_d;
      v_q    <= v_d;
      mode_q <= mode_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      de_q   <= de_d;
      fs_q   <= fs_d;
      rgb_q  <= rgb_d;
    end
  end

  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign de          = de_q;
  assign frame_start = fs_q;
  assign red         = rgb_q[23:16];
  assign green       = rgb_q[15:8];
  assign blue        = rgb_q[7:0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a small 32x10 raster (16x4 active) with CLK_DIV=2.
module tb_vga_timing_gen;

  // Raster: H 8/4/16/4 (total 32), V 2/2/4/2 (total 10); pixel index n -> h=n%32, v=(n/32)%10.
  // Registered outputs for index n are visible after release edge 2n+2; pe/pix_req at edge 2n+1.
  logic        clk_50m = 1'b0;
  logic        rst_n;
  logic [1:0]  mode;
  logic [23:0] rgb_in;
  logic        pix_req;
  logic [3:0]  pix_x;
  logic [1:0]  pix_y;
  logic [7:0]  red, green, blue;
  logic        hsync, vsync, de, frame_start;
  logic [23:0] rgb_o;

  int total = 0;
  int bad   = 0;
  int edges = 0;

  vga_timing_gen #(
    .CLK_DIV (2),
    .H_SYNC  (8),
    .H_BP    (4),
    .H_ACT   (16),
    .H_FP    (4),
    .V_SYNC  (2),
    .V_BP    (2),
    .V_ACT   (4),
    .V_FP    (2),
    .SYNC_POL(1'b0),
    .GRID    (4)
  ) dut (
    .clk_50m     (clk_50m),
    .rst_n       (rst_n),
    .mode        (mode),
    .rgb_in      (rgb_in),
    .pix_req     (pix_req),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .hsync       (hsync),
    .vsync       (vsync),
    .de          (de),
    .frame_start (frame_start)
  );

  always #5 clk_50m = ~clk_50m;

  // Pixel source answering pix_req: {x, y, 5A}
  assign rgb_in = {4'h0, pix_x, 6'h0, pix_y, 8'h5A};
  assign rgb_o  = {red, green, blue};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after release-relative edge 'target', sampling on the following negedge
  task automatic adv(input int target);
    if (target <= edges) begin
      chk("schedule", 32'(target), 32'(edges + 1));
    end else begin
      while (edges < target) begin
        @(posedge clk_50m);
        edges++;
      end
      @(negedge clk_50m);
    end
  endtask

  int n_req, n_fs, n_rgb, n_de, n_hs, n_vs;

  initial begin
    rst_n = 1'b0;
    mode  = 2'd0;
    repeat (3) @(posedge clk_50m);
    @(negedge clk_50m);
    chk("rst_de", 32'(de), 32'h0);
    chk("rst_hsync", 32'(hsync), 32'h1);
    chk("rst_vsync", 32'(vsync), 32'h1);
    chk("rst_rgb", 32'(rgb_o), 32'h0);
    chk("rst_fs", 32'(frame_start), 32'h0);
    chk("rst_req", 32'(pix_req), 32'h0);
    rst_n = 1'b1;
    edges = 0;

    // Frame 0: external source, timing boundaries
    adv(2);    chk("f0_hs_n0", 32'(hsync), 32'h0);
               chk("f0_vs_n0", 32'(vsync), 32'h0);
               chk("f0_de_n0", 32'(de), 32'h0);
    adv(16);   chk("hs_n7", 32'(hsync), 32'h0);
    adv(18);   chk("hs_n8", 32'(hsync), 32'h1);
    adv(128);  chk("vs_n63", 32'(vsync), 32'h0);
    adv(130);  chk("vs_n64", 32'(vsync), 32'h1);
    adv(280);  chk("de_n139", 32'(de), 32'h0);
    adv(281);  chk("req_n140", 32'(pix_req), 32'h1);
               chk("px_n140", 32'(pix_x), 32'h0);
               chk("py_n140", 32'(pix_y), 32'h0);
    adv(282);  chk("req_n140_off", 32'(pix_req), 32'h0);
               chk("px_n141", 32'(pix_x), 32'h1);
               chk("de_n140", 32'(de), 32'h1);
               chk("fs_n140", 32'(frame_start), 32'h1);
               chk("ext_0_0", 32'(rgb_o), 32'h00005A);
    adv(283);  chk("fs_pulse_end", 32'(frame_start), 32'h0);
               chk("de_hold", 32'(de), 32'h1);
    adv(284);  chk("ext_1_0", 32'(rgb_o), 32'h01005A);
    adv(312);  chk("ext_15_0", 32'(rgb_o), 32'h0F005A);
               chk("de_n155", 32'(de), 32'h1);
    adv(314);  chk("de_n156", 32'(de), 32'h0);
               chk("blank_rgb", 32'(rgb_o), 32'h0);
    adv(315);  chk("blank_req", 32'(pix_req), 32'h0);
               chk("blank_px", 32'(pix_x), 32'h0);
    adv(402);  mode = 2'd2;
    adv(504);  chk("ext_15_3_notear", 32'(rgb_o), 32'h0F035A);

    // Frame 1: grid, pitch 4
    adv(932);  chk("grid_5_0", 32'(rgb_o), 32'hFFFFFF);
    adv(988);  chk("grid_1_1", 32'(rgb_o), 32'h000000);
               chk("grid_de", 32'(de), 32'h1);
    adv(994);  chk("grid_4_1", 32'(rgb_o), 32'hFFFFFF);
    adv(1050); chk("grid_0_2", 32'(rgb_o), 32'hFFFFFF);
    adv(1100); mode = 2'd1;

    // Frame 2: colour bars, 2 pixels wide, on line y=1
    adv(1626); chk("bar_x0", 32'(rgb_o), 32'hFFFFFF);
    adv(1628); chk("bar_x1", 32'(rgb_o), 32'hFFFFFF);
    adv(1630); chk("bar_x2", 32'(rgb_o), 32'hFFFF00);
    adv(1634); chk("bar_x4", 32'(rgb_o), 32'h00FFFF);
    adv(1638); chk("bar_x6", 32'(rgb_o), 32'h00FF00);
    adv(1642); chk("bar_x8", 32'(rgb_o), 32'hFF00FF);
    adv(1646); chk("bar_x10", 32'(rgb_o), 32'hFF0000);
    adv(1650); chk("bar_x12", 32'(rgb_o), 32'h0000FF);
    adv(1654); chk("bar_x14", 32'(rgb_o), 32'h000000);
    adv(1700); mode = 2'd3;

    // Frame 3: black mode, whole-frame tallies over 640 clocks
    adv(1920);
    n_req = 0; n_fs = 0; n_rgb = 0; n_de = 0; n_hs = 0; n_vs = 0;
    for (int i = 0; i < 640; i++) begin
      adv(edges + 1);
      if (pix_req)      n_req++;
      if (frame_start)  n_fs++;
      if (rgb_o != '0)  n_rgb++;
      if (de)           n_de++;
      if (!hsync)       n_hs++;
      if (!vsync)       n_vs++;
    end
    chk("frame_req_cnt", 32'(n_req), 32'd64);
    chk("frame_fs_cnt", 32'(n_fs), 32'd1);
    chk("black_rgb_cnt", 32'(n_rgb), 32'd0);
    chk("frame_de_clks", 32'(n_de), 32'd128);
    chk("frame_hs_clks", 32'(n_hs), 32'd160);
    chk("frame_vs_clks", 32'(n_vs), 32'd128);

    // Frame 4: reset in the middle of an active line
    adv(2974); chk("pre_rst_de", 32'(de), 32'h1);
    rst_n = 1'b0;
    repeat (3) @(posedge clk_50m);
    @(negedge clk_50m);
    chk("mid_rst_de", 32'(de), 32'h0);
    chk("mid_rst_hs", 32'(hsync), 32'h1);
    chk("mid_rst_vs", 32'(vsync), 32'h1);
    chk("mid_rst_rgb", 32'(rgb_o), 32'h0);
    chk("mid_rst_req", 32'(pix_req), 32'h0);
    chk("mid_rst_px", 32'(pix_x), 32'h0);
    mode  = 2'd1;
    rst_n = 1'b1;
    edges = 0;
    adv(1);    chk("rel_vs_e1", 32'(vsync), 32'h1);
    adv(2);    chk("rel_vs_e2", 32'(vsync), 32'h0);
               chk("rel_hs_e2", 32'(hsync), 32'h0);
    while (!frame_start && edges < 2000) adv(edges + 1);
    chk("restart_fs_edge", 32'(edges), 32'd282);
    chk("restart_de", 32'(de), 32'h1);
    chk("restart_bar0", 32'(rgb_o), 32'hFFFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
